// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared widths, opcodes and instruction field helpers for the fetch stage.
package fetch_sequencer_pkg;

    localparam int unsigned INSN_W = 28;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned IMM_W  = 24;

    // Instruction fields: opcode [27:24], jump/call target [23:16], immediate [23:0].
    localparam int unsigned OPC_LSB = 24;
    localparam int unsigned TGT_LSB = 16;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_CALL = 4'h2;
    localparam logic [3:0] OP_RET  = 4'h3;
    localparam logic [3:0] OP_BLE  = 4'h4;
    localparam logic [3:0] OP_BGE  = 4'h5;

    localparam logic [INSN_W-1:0] NOP_WORD = {OP_NOP, 24'd0};

    function automatic logic [3:0] insn_opcode(input logic [INSN_W-1:0] word);
        return word[OPC_LSB+:4];
    endfunction

    // 8-bit target zero-extended to a full address.
    function automatic logic [ADDR_W-1:0] insn_target(input logic [INSN_W-1:0] word);
        return {8'd0, word[TGT_LSB+:8]};
    endfunction

    function automatic logic [IMM_W-1:0] insn_imm(input logic [INSN_W-1:0] word);
        return word[IMM_W-1:0];
    endfunction

endpackage

// File: rtl/fetch_sequencer_return_stack.sv
// fetch_sequencer_return_stack: LIFO of return addresses; push ignored when full,
// pop ignored when empty. Contents are not reset, only the pointer.
module fetch_sequencer_return_stack
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iPush,
    input  logic              iPop,
    input  logic [ADDR_W-1:0] iData,
    output logic [ADDR_W-1:0] oData,
    output logic              oFull,
    output logic              oEmpty
);

    localparam int unsigned     PTR_W    = $clog2(STACK_DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(STACK_DEPTH);

    // r_ptr counts occupied entries; one extra bit distinguishes full from empty.
    logic [PTR_W:0]    r_ptr;
    logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
    logic [PTR_W-1:0]  w_top_idx;

    assign w_top_idx = r_ptr[PTR_W-1:0] - PTR_W'(1);
    assign oData     = r_mem[w_top_idx];
    assign oFull     = (r_ptr == FULL_CNT);
    assign oEmpty    = (r_ptr == '0);

    // Occupancy pointer.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_ptr <= '0;
        end else if (iPush && !oFull) begin
            r_ptr <= r_ptr + (PTR_W + 1)'(1);
        end else if (iPop && !oEmpty) begin
            r_ptr <= r_ptr - (PTR_W + 1)'(1);
        end
    end

    // Entry storage, written at the current occupancy index.
    always_ff @(posedge Clock) begin
        if (iPush && !oFull) begin
            r_mem[r_ptr[PTR_W-1:0]] <= iData;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC and instruction-fetch stage. Resolves JMP/CALL/RET locally,
// takes redirects from execute, and presents fetched words in a valid/ready slot.
// Build macro FETCH_NOP_DELAY_EN: an accepted NOP with nonzero imm24 stalls fetch
// for imm24 cycles before resuming at the next address.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned       STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = 16'd0
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic [ADDR_W-1:0] oAddress,
    input  logic [INSN_W-1:0] iInstruction,
    output logic [INSN_W-1:0] oInstruction,
    output logic [ADDR_W-1:0] oPC,
    output logic              oValid,
    input  logic              iReady,
    input  logic              iBranchTaken,
    input  logic [ADDR_W-1:0] iBranchTarget,
    output logic              oStackError
);

`ifdef FETCH_NOP_DELAY_EN
    typedef enum logic [1:0] {StRun, StHold, StDelay} state_e;
`else
    typedef enum logic [0:0] {StRun, StHold} state_e;
`endif

    state_e            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_opc;
    logic [INSN_W-1:0] r_insn;
    logic              r_valid;
    logic              r_err;
`ifdef FETCH_NOP_DELAY_EN
    logic [IMM_W-1:0]  r_cnt;
    logic              w_nop_accept;
`endif

    logic              w_adv;
    logic              w_fetch;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_stack_err;
    logic [3:0]        w_opcode;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_stack_top;

    assign oAddress     = r_pc;
    assign oInstruction = r_insn;
    assign oPC          = r_opc;
    assign oValid       = r_valid;
    assign oStackError  = r_err;

    assign w_opcode = insn_opcode(iInstruction);
    assign w_pc_inc = r_pc + 16'd1;
    // The slot can take a new word when it is empty or being drained this cycle.
    assign w_adv    = !(r_valid || (r_state == StHold)) || iReady;

    // Decide whether this cycle performs a fetch; a redirect cancels it.
    always_comb begin
        w_fetch = w_adv && !iBranchTaken;
`ifdef FETCH_NOP_DELAY_EN
        w_nop_accept = r_valid && iReady && (insn_opcode(r_insn) == OP_NOP) &&
                       (insn_imm(r_insn) != '0);
        if (r_state == StDelay) begin
            w_fetch = !iBranchTaken && (r_cnt <= 24'd1);
        end else if (w_nop_accept) begin
            w_fetch = 1'b0;
        end
`endif
    end

    // Next PC and stack operations for the word being fetched.
    always_comb begin
        w_pc_next   = w_pc_inc;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_stack_err = 1'b0;
        case (w_opcode)
            OP_JMP: w_pc_next = insn_target(iInstruction);
            OP_CALL: begin
                w_pc_next   = insn_target(iInstruction);
                w_push      = w_fetch && !w_full;
                w_stack_err = w_full;
            end
            OP_RET: begin
                w_pc_next   = w_empty ? RESET_PC : w_stack_top;
                w_pop       = w_fetch && !w_empty;
                w_stack_err = w_empty;
            end
            default: ;
        endcase
    end

    fetch_sequencer_return_stack #(
        .STACK_DEPTH(STACK_DEPTH)
    ) u_return_stack (
        .Clock (Clock),
        .Reset (Reset),
        .iPush (w_push),
        .iPop  (w_pop),
        .iData (w_pc_inc),
        .oData (w_stack_top),
        .oFull (w_full),
        .oEmpty(w_empty)
    );

    // Fetch FSM: PC, output slot, sticky error and run/hold/delay state.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= StRun;
            r_pc    <= RESET_PC;
            r_opc   <= '0;
            r_insn  <= NOP_WORD;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
`ifdef FETCH_NOP_DELAY_EN
            r_cnt   <= '0;
`endif
        end else if (iBranchTaken) begin
            r_pc    <= iBranchTarget;
            r_valid <= 1'b0;
            r_state <= StRun;
        end else if (w_fetch) begin
            r_pc    <= w_pc_next;
            r_insn  <= iInstruction;
            r_opc   <= r_pc;
            r_valid <= 1'b1;
            r_state <= StRun;
            if (w_stack_err) begin
                r_err <= 1'b1;
            end
`ifdef FETCH_NOP_DELAY_EN
        end else if (r_state == StDelay) begin
            r_cnt <= (r_cnt == '0) ? '0 : r_cnt - 24'd1;
        end else if (w_nop_accept) begin
            r_valid <= 1'b0;
            r_cnt   <= insn_imm(r_insn);
            r_state <= StDelay;
`endif
        end else if (r_valid && !iReady) begin
            r_state <= StHold;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level model (queue-based return stack, ROM lookup by model PC).
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam int          DEPTH  = 8;
    localparam logic [15:0] RST_PC = 16'd0;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] oAddress;
    logic [27:0] iInstruction;
    logic [27:0] oInstruction;
    logic [15:0] oPC;
    logic        oValid;
    logic        iReady;
    logic        iBranchTaken;
    logic [15:0] iBranchTarget;
    logic        oStackError;

    logic [27:0] rom [256];
    assign iInstruction = rom[oAddress[7:0]];

    always #5 Clock = ~Clock;

    fetch_sequencer #(
        .STACK_DEPTH(DEPTH),
        .RESET_PC   (RST_PC)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .oAddress     (oAddress),
        .iInstruction (iInstruction),
        .oInstruction (oInstruction),
        .oPC          (oPC),
        .oValid       (oValid),
        .iReady       (iReady),
        .iBranchTaken (iBranchTaken),
        .iBranchTarget(iBranchTarget),
        .oStackError  (oStackError)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [15:0] m_pc;
    logic [15:0] m_opc;
    logic [27:0] m_insn;
    logic        m_valid;
    logic        m_err;
    logic [15:0] m_stack [$];
    int          m_delay;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s at %0t: observed 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = RST_PC;
        m_opc   = 16'd0;
        m_insn  = NOP_WORD;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_delay = 0;
        m_stack.delete();
    endtask

    // One clock of the architectural rules, applied to the model.
    task automatic model_step(input logic rdy, input logic br, input logic [15:0] tgt);
        logic [27:0] w;
        w = rom[m_pc[7:0]];
        if (br) begin
            m_pc    = tgt;
            m_valid = 1'b0;
            m_delay = 0;
            return;
        end
`ifdef FETCH_NOP_DELAY_EN
        // m_delay = dead cycles still owed after the current one.
        if (m_delay > 0) begin
            m_delay--;
            return;
        end
        if (m_valid && rdy && m_insn[27:24] == OP_NOP && m_insn[23:0] != '0) begin
            m_valid = 1'b0;
            m_delay = int'(m_insn[23:0]) - 1;
            return;
        end
`endif
        if (m_valid && !rdy) return;
        m_insn  = w;
        m_opc   = m_pc;
        m_valid = 1'b1;
        case (w[27:24])
            OP_JMP: m_pc = {8'd0, w[23:16]};
            OP_CALL: begin
                if (m_stack.size() < DEPTH) m_stack.push_back(m_pc + 16'd1);
                else m_err = 1'b1;
                m_pc = {8'd0, w[23:16]};
            end
            OP_RET: begin
                if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else begin
                    m_pc  = RST_PC;
                    m_err = 1'b1;
                end
            end
            default: m_pc = m_pc + 16'd1;
        endcase
    endtask

    task automatic check_outputs();
        chk("addr", 32'(oAddress), 32'(m_pc));
        chk("valid", 32'(oValid), 32'(m_valid));
        chk("stack_err", 32'(oStackError), 32'(m_err));
        if (m_valid) begin
            chk("pc", 32'(oPC), 32'(m_opc));
            chk("insn", 32'(oInstruction), 32'(m_insn));
        end
    endtask

    task automatic step(input logic rdy, input logic br, input logic [15:0] tgt);
        iReady        = rdy;
        iBranchTaken  = br;
        iBranchTarget = tgt;
        model_step(rdy, br, tgt);
        @(posedge Clock);
        @(negedge Clock);
        iBranchTaken = 1'b0;
        check_outputs();
    endtask

    // Asynchronous reset between clock edges, held across one rising edge.
    task automatic do_reset();
        #2;
        Reset = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("rst_insn", 32'(oInstruction), 32'(NOP_WORD));
        chk("rst_pc", 32'(oPC), 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    function automatic logic [27:0] rand_word();
        logic [27:0] w;
        w = NOP_WORD;
        case ($urandom_range(0, 7))
            0: w = {OP_NOP, 21'd0, 3'($urandom_range(0, 3))};
            1: w = {OP_JMP, 8'($urandom), 16'($urandom)};
            2: w = {OP_CALL, 8'($urandom), 16'($urandom)};
            3: w = {OP_RET, 24'($urandom)};
            4: w = {OP_BLE, 24'($urandom)};
            5: w = {OP_BGE, 24'($urandom)};
            default: w = {4'hA + 4'($urandom_range(0, 3)), 24'($urandom)};
        endcase
        return w;
    endfunction

    initial begin
        logic [15:0] exp_addr [8];
        logic        rdy;
        logic        br;
        logic        prev_br;
        logic [15:0] tgt;

        iReady        = 1'b1;
        iBranchTaken  = 1'b0;
        iBranchTarget = 16'd0;
        for (int i = 0; i < 256; i++) rom[i] = NOP_WORD;
        rom[5]  = {OP_JMP, 8'd35, 16'd0};
        rom[35] = {OP_JMP, 8'd35, 16'd0};
        rom[6]  = {OP_CALL, 8'd50, 16'd0};
        rom[66] = {OP_RET, 24'd0};
        // Nested chain: CALL at 100+2k jumps to the next CALL; each return lands on a RET.
        for (int k = 0; k <= DEPTH; k++) begin
            rom[100 + 2 * k] = {OP_CALL, 8'(102 + 2 * k), 16'd0};
            if (k < DEPTH) rom[101 + 2 * k] = {OP_RET, 24'd0};
        end
        rom[100 + 2 * (DEPTH + 1)] = {OP_RET, 24'd0};
`ifdef FETCH_NOP_DELAY_EN
        rom[200] = {OP_NOP, 24'd4};
`endif

        // Reset, sequential fetch, then JMP 5->35 and the self-loop on 35.
        exp_addr = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd35, 16'd35, 16'd35};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 16'd0);
            chk("seq_addr", 32'(oAddress), 32'(exp_addr[i]));
            if (i == 0) begin
                chk("first_pc", 32'(oPC), 32'd0);
                chk("first_valid", 32'(oValid), 32'd1);
            end
        end

        // CALL 50 at 6, RET at 66: order 6, 50..66, 7.
        step(1'b1, 1'b1, 16'd6);
        for (int i = 0; i < 19; i++) begin
            step(1'b1, 1'b0, 16'd0);
            chk("call_order", 32'(oPC), (i == 0) ? 32'd6 : (i == 18) ? 32'd7 : 32'(49 + i));
        end

        // Hold with oPC=9 for three cycles.
        step(1'b1, 1'b0, 16'd0);
        step(1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 16'd0);
            chk("hold_pc", 32'(oPC), 32'd9);
            chk("hold_addr", 32'(oAddress), 32'd10);
            chk("hold_insn", 32'(oInstruction), 32'(NOP_WORD));
        end
        step(1'b1, 1'b0, 16'd0);
        chk("resume_pc", 32'(oPC), 32'd10);

        // Redirect to 5 while oPC=8 is held: flush, then 5 two cycles after the pulse.
        step(1'b1, 1'b1, 16'd7);
        step(1'b1, 1'b0, 16'd0);
        step(1'b1, 1'b0, 16'd0);
        chk("pre_redirect_pc", 32'(oPC), 32'd8);
        step(1'b0, 1'b1, 16'd5);
        chk("flush_valid", 32'(oValid), 32'd0);
        step(1'b1, 1'b0, 16'd0);
        chk("redirect_pc", 32'(oPC), 32'd5);
        chk("redirect_valid", 32'(oValid), 32'd1);

        // PC wrap from 16'hFFFF to 0.
        step(1'b1, 1'b1, 16'hFFFF);
        step(1'b1, 1'b0, 16'd0);
        chk("wrap_pc", 32'(oPC), 32'hFFFF);
        chk("wrap_addr", 32'(oAddress), 32'd0);

        // DEPTH+1 nested CALLs: error on the overflow CALL, sticky through empty RET.
        step(1'b1, 1'b1, 16'd100);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 16'd0);
        chk("no_err_at_full", 32'(oStackError), 32'd0);
        step(1'b1, 1'b0, 16'd0);
        chk("overflow_err", 32'(oStackError), 32'd1);
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 1'b0, 16'd0);
        chk("underflow_pc", 32'(oPC), 32'd101);
        chk("underflow_addr", 32'(oAddress), 32'(RST_PC));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'd0);
        chk("err_sticky", 32'(oStackError), 32'd1);

`ifdef FETCH_NOP_DELAY_EN
        begin
            int zeros;
            zeros = 0;
            step(1'b1, 1'b1, 16'd200);
            step(1'b1, 1'b0, 16'd0);
            chk("delay_nop_pc", 32'(oPC), 32'd200);
            for (int i = 0; i < 20; i++) begin
                step(1'b1, 1'b0, 16'd0);
                if (oValid) break;
                zeros++;
            end
            chk("delay_zero_cycles", 32'(zeros), 32'd4);
            chk("delay_resume_pc", 32'(oPC), 32'd201);
        end
`endif

        // Randomized program and traffic, with a reset in the middle.
        for (int i = 0; i < 256; i++) rom[i] = rand_word();
        do_reset();
        prev_br = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            rdy = ($urandom_range(0, 3) != 0);
            br  = !prev_br && ($urandom_range(0, 11) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            step(rdy, br, tgt);
            prev_br = br;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and instruction-fetch stage between the instruction ROM (combinational, 16-bit address, 28-bit word) and the decode/execute stage.
- Drives the ROM address and registers the returned word into a valid/ready output slot.
- Resolves JMP/CALL/RET locally using a return-address stack.
- Accepts taken-branch redirects (BLE/BGE) from execute and flushes the wrong-path slot.

Parameters:
- STACK_DEPTH, 8, number of return-address entries (power of 2, ≥2).
- RESET_PC, 16'd0, first address fetched after reset.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  reset; one clock; reset is asynchronous and active-low.
- oAddress  out  16  ROM address (current PC).
- iInstruction  in  28  ROM word at oAddress, same cycle.
- oInstruction  out  28  registered instruction to decode.
- oPC  out  16  address oInstruction was fetched from.
- oValid  out  1  oInstruction holds a live instruction.
- iReady  in  1  decode accepts the slot this cycle.
- iBranchTaken  in  1  execute redirect, single-cycle pulse.
- iBranchTarget  in  16  redirect address.
- oStackError  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset values: PC=RESET_PC, oAddress=RESET_PC, oInstruction={`NOP,24'd0}, oPC=0, oValid=0, stack pointer=0, oStackError=0.
- Opcode = word[27:24]; 8-bit jump/call target = word[23:16], zero-extended to 16 bits.
- Advance condition: adv = !oValid || iReady.
- On adv, with no redirect:
  - latch oInstruction=iInstruction, oPC=PC, oValid=1.
  - JMP: PC=target.
  - CALL: push PC+1, then PC=target.
  - RET: pop into PC.
  - Otherwise: PC=PC+1, wrapping 16'hFFFF→0.
- Latency: address presented in cycle n; its word is at the output from cycle n+1. Throughput is 1 per cycle while iReady=1.
- Hold: oValid && !iReady keeps PC, the output slot and the stack unchanged. The output is stable until accepted.
- Redirect: iBranchTaken=1 has priority over everything.
  - PC=iBranchTarget, oValid=0 next cycle (wrong-path slot flushed).
  - The fetch in that cycle is cancelled, including any push/pop it would have done.
  - The first redirected word is valid 2 cycles after the pulse.
  - Redirect is honoured even while holding.
- Stack full + CALL: push dropped, jump still taken, oStackError=1.
- Stack empty + RET: PC=RESET_PC, oStackError=1.
- oStackError clears only on reset.
- JMP/CALL/RET are still forwarded downstream as ordinary slots; execute treats them as no-ops.
- States: RUN, HOLD, DELAY (DELAY exists only with the feature below). Reset→RUN; RUN→HOLD when oValid && !iReady; HOLD→RUN when iReady.
- Reset asserted mid-operation immediately returns all state to the reset values. The stack contents are don't-care.

Optional Feature:
- Macro FETCH_NOP_DELAY_EN.
- Defined:
  - A NOP with nonzero imm24 = N, once accepted downstream, enters DELAY.
  - DELAY holds PC for N cycles with oValid=0, then resumes at PC+1.
  - A redirect aborts DELAY immediately.
  - The 24-bit counter saturates at 0.
- Undefined: NOP is a plain 1-cycle slot and imm24 is ignored.

Decomposition:
- Shared package/definitions: opcode constants (`NOP, `JMP, `CALL, `RET, `BLE, `BGE), instruction field bit positions, INSN_W=28, ADDR_W=16, and the NOP reset word.
- One sub-module: return_stack, a LIFO with push/pop/full/empty/data_out and the same Clock/Reset.

Test Plan:
1. Reset release, iReady=1, ROM holds NOP at 0..3: oAddress=0,1,2,3 on successive cycles; oPC=0 and oValid=1 in the first cycle after reset release.
2. Addr 5 = JMP 35, iReady=1: the sequence is 5 then 35 with no bubble. With ROM addr 35 = JMP 35, the fetch loops on 35 forever.
3. CALL 50 at addr 6; RET at 66: fetch order 6,50..66,7; the stack is empty after the RET.
4. iReady low for 3 cycles with oPC=9: oInstruction/oPC stay stable and oAddress stays 10; resume delivers 10.
5. iBranchTaken with target 5 while oPC=8 and oValid=1: next cycle oValid=0; the following cycle oPC=5.
6. STACK_DEPTH+1 nested CALLs, then RET on an empty stack: oStackError rises on the overflow CALL and stays 1. With FETCH_NOP_DELAY_EN defined, NOP 24'd4: exactly 4 oValid=0 cycles before PC+1.
